// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: streams operands LSB-nibble-first through a
// single 4-bit carry-lookahead slice, chaining the carry through a register.

module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
        sum  = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int N  = WIDTH / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nx;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;
    logic [3:0]       nib_sum;
    logic             nib_cout;
    logic             last;

    cla4 u_slice (
        .a    (sh_a[3:0]),
        .b    (sh_b[3:0]),
        .cin  (carry),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Each new nibble enters at the top; after N shifts the result is aligned.
    if (WIDTH == 4) begin : g_acc_single
        assign acc_nx = nib_sum;
    end else begin : g_acc_shift
        assign acc_nx = {nib_sum, acc[WIDTH-1:4]};
    end

    assign last      = (cnt == CW'(N - 1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid)  state_nx = RUN;
            RUN:     if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a  <= '0;
            sh_b  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        sh_a  <= a;
                        sh_b  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    acc   <= acc_nx;
                    carry <= nib_cout;
                    sh_a  <= sh_a >> 4;
                    sh_b  <= sh_b >> 4;
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        sum  <= acc_nx;
                        cout <= nib_cout;
                        // carry into the MSB recovered from the MSB sum bit
                        ovf  <= nib_cout ^ (a_msb ^ b_msb ^ acc_nx[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle wide adder that sits directly upstream of the codebase's 4-bit carry-lookahead adder slice. It accepts WIDTH-bit operand pairs over a valid/ready handshake and feeds the slice one nibble per cycle, least-significant nibble first. It consumes the slice's sum and carry-out each cycle, chaining the carry through a register. The assembled WIDTH-bit result, carry-out and signed-overflow flag are presented over a second valid/ready handshake.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; N = WIDTH/4 nibble cycles per operation
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block can accept; high only in IDLE
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in to the least-significant nibble
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  signed overflow: carry into the MSB XOR cout

## Operation
- One clock domain; reset is asynchronous and active-low.
- Reset values: state IDLE, out_valid 0, sum 0, cout 0, ovf 0, nibble counter 0, carry register 0, operand shift registers 0. in_ready = (state == IDLE).
- Sub-block: a single instance of the 4-bit carry-lookahead slice. Its inputs are the low nibbles of the A/B shift registers and the carry register. Its outputs are nibble sum and slice cout.
- FSM states:
  - IDLE: in_ready = 1. On in_valid && in_ready, capture a and b into the shift registers, load cin into the carry register, clear the counter, and go to RUN.
  - RUN: every cycle, shift the slice sum into the top of the internal accumulator (shift right by 4), load the carry register with slice cout, shift A/B right by 4, and increment the counter. On the edge that processes nibble N-1, go to DONE. On that same edge, load sum from the completed accumulator value and load cout from slice cout. Also load ovf = slice cout XOR (a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1]), using the captured operand MSBs; a/b MSBs are saved at capture.
  - DONE: out_valid = 1. sum, cout and ovf are held stable. On out_valid && out_ready, go to IDLE and clear out_valid.
- sum, cout and ovf change only on the edge entering DONE (or on reset). After a pop they retain the last result.
- in_valid is ignored in RUN and DONE. Operand changes after the accept edge have no effect.
- Arithmetic is modulo 2^WIDTH. The carry register is exactly 1 bit. The counter is wide enough to hold N-1.
- Reset mid-RUN or mid-DONE aborts the operation: all state returns to reset values immediately and the result is discarded.

## Timing
- Accept at edge E0 (in_valid && in_ready sampled high).
- Nibble i is computed combinationally during cycle i and registered at edge E(i+1), for i = 0..N-1.
- out_valid rises after edge EN. Latency from the accept edge is N cycles.
- Earliest pop is edge E(N+1), with out_ready held high. in_ready returns high after the pop edge.
- Earliest next accept is edge E(N+2). Sustained throughput is one operation per N+2 cycles.
- in_ready is low from the cycle after E0 until the cycle after the pop edge.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- The critical path is a single 4-bit lookahead slice plus the register setup.

## Test plan
- WIDTH=16: a=0x1234, b=0x4321, cin=0 → sum 0x5555, cout 0, ovf 0. out_valid first high exactly 4 cycles after the accept edge.
- WIDTH=16, full carry chain: a=0xFFFF, b=0x0000, cin=1 → sum 0x0000, cout 1, ovf 0. Then a=0xFFFF, b=0xFFFF, cin=1 → sum 0xFFFF, cout 1, ovf 0.
- WIDTH=16, signed overflow: a=0x7FFF, b=0x0001, cin=0 → sum 0x8000, cout 0, ovf 1. Then a=0x8000, b=0x8000 → sum 0x0000, cout 1, ovf 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises. Required: out_valid, sum, cout and ovf stay stable; in_ready stays 0; in_valid pulses with new operands are ignored. Raise out_ready → pop at that edge, in_ready is 1 the next cycle, and the next op accepts correctly.
- Reset mid-RUN: drive rst_n low asynchronously after 2 of 4 nibble cycles. Required: out_valid, sum, cout and ovf read 0 immediately, and in_ready is 1 after rst_n rises. A following op with a=0x00FF, b=0x0001, cin=0 gives sum 0x0100, cout 0.
- WIDTH=4 instance: a=0x9, b=0x8, cin=1 → sum 0x2, cout 1, ovf 1. Latency 1 cycle, throughput 1 op per 3 cycles under back-to-back valid with out_ready=1.
